aes_round_ctrl: RTL
===================

// Module: aes_round_ctrl
// PURPOSE
//  Round sequencer for the AES-128 encryption datapath. It steps the state register through
//  AddRoundKey, then NR rounds of SubBytes, ShiftRows, MixColumns and AddRoundKey.
//  The final round skips MixColumns. It drives one-hot stage strobes to the datapath,
//  requests round keys from the key expander, and handshakes with the MixColumns unit
//  over its enable/done pair. It sits between the top-level start/done interface and the
//  round-function units.
// PARAMETERS
//  NR           10  number of rounds; round counter runs 0..NR
//  ROUND_W      4   width of round_num; must hold NR
//  MIX_TIMEOUT  8   max cycles in MIX without mix_done before err is raised
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  reset      in   1        synchronous, active-low; 0 at a rising edge = reset
//  start      in   1        begin encryption; sampled only in IDLE or ERR
//  key_valid  in   1        round key for round_num is available to the ARK stage
//  mix_done   in   1        MixColumns unit done flag; registered, 1 cycle after mix_en sampled
//  load_en    out  1        latch plaintext and cipher key into datapath registers
//  sub_en     out  1        apply SubBytes to state register
//  shift_en   out  1        apply ShiftRows to state register
//  mix_en     out  1        MixColumns enable; held until mix_done seen
//  ark_en     out  1        XOR round key into state register
//  key_req    out  1        1-cycle request to key expander for key of round_num
//  round_num  out  ROUND_W  current round, 0 = initial AddRoundKey
//  busy       out  1        high in every state except IDLE and ERR
//  done       out  1        1-cycle pulse; ciphertext valid in state register
//  err        out  1        MixColumns timeout; held until next start or reset
// BEHAVIOUR
//  - Moore FSM. All outputs decode from registered state and counters only; there is no
//    input-to-output combinational path. Exception: ark_en = (state==ARK) & key_valid.
//  - Reset (reset==0 at an edge), from any state: state=IDLE, round_num=0, mix counter=0.
//    All outputs 0 the following cycle. Reset mid-operation abandons the block; nothing is
//    retained.
//  - States and transitions:
//    IDLE : start -> LOAD. Otherwise stay.
//    LOAD : load_en=1, round_num<=0 -> ARK. Lasts 1 cycle.
//    ARK  : stall while key_valid==0. When key_valid==1: ark_en=1 that cycle, then
//           if round_num==NR -> DONE, else round_num<=round_num+1 -> SUB.
//    SUB  : sub_en=1. key_req=1 (round_num is the new round) -> SHIFT. Lasts 1 cycle.
//    SHIFT: shift_en=1. If round_num==NR -> ARK, else -> MIX. Lasts 1 cycle.
//    MIX  : mix_en=1 every cycle in this state; mix counter increments each cycle.
//           If mix_done==1 -> ARK, counter cleared.
//           Else if counter==MIX_TIMEOUT-1 -> ERR.
//           Nominal stay is 2 cycles: enable cycle, then done cycle.
//    DONE : done=1 -> IDLE. Lasts 1 cycle. start here is ignored.
//    ERR  : err=1, busy=0. start -> LOAD, and err clears in LOAD. Otherwise stay.
//  - start while busy is ignored; it is not queued.
//  - mix_done is looked at only in MIX. A stale mix_done=1 in the ARK cycle after MIX has
//    no effect.
//  - round_num changes only in LOAD (to 0) and on ARK completion (increment).
//    It never exceeds NR.
//  - Zero-stall latency, NR=10: with start sampled at edge E0, done is high in cycle 51
//    after E0. Breakdown: LOAD 1 + ARK 1 + 9 x (SUB,SHIFT,MIX x2,ARK) + SUB,SHIFT,ARK
//    = 50 cycles, then DONE.
//  - Each key_valid=0 cycle in ARK, and each extra MIX cycle, adds exactly 1 cycle.
// TESTING
//  1 Nominal: reset=0 for 2 cycles, start pulse, key_valid=1, MixColumns model with
//    1-cycle done -> done in cycle 51. Also: round_num sequence 0,1..10; 11 ark_en pulses;
//    10 key_req; 9 mix_en windows of 2 cycles; no mix_en in round 10.
//  2 Key stall: key_valid=0 for 3 cycles at the round-4 ARK -> round_num holds 4, ark_en=0
//    during the stall, done in cycle 54.
//  3 Mix timeout: mix_done tied 0 -> err=1 and busy=0 after 8 MIX cycles in round 1.
//    err holds. A start then clears err and a nominal run completes in 51 cycles.
//  4 Start filtering: start held high for a whole run -> no restart until IDLE.
//    start in the DONE cycle is ignored. start in the first IDLE cycle starts a new run,
//    with done 51 cycles later.
//  5 Reset mid-op: reset=0 for 1 cycle during round-5 MIX -> next cycle all outputs 0 and
//    round_num=0. A fresh start completes in 51 cycles.
//  6 Ciphertext check with the real datapath: FIPS-197 App. B vector, key
//    2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//    -> 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 encryption datapath.
// Drives one-hot stage strobes, requests round keys and handshakes with the
// MixColumns unit. Outputs decode from registered state; ark_en alone also
// depends on key_valid.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | latch plaintext and key, clear round counter
// S_ARK   | AddRoundKey, stalls until key_valid
// S_SUB   | SubBytes, request key for the new round
// S_SHIFT | ShiftRows, final round bypasses MixColumns
// S_MIX   | MixColumns enable held until mix_done, bounded by timeout
// S_DONE  | one-cycle completion pulse
// S_ERR   | MixColumns timed out; waits for a fresh start
module aes_round_ctrl #(
  parameter int NR          = 10,
  parameter int ROUND_W     = 4,
  parameter int MIX_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_valid,
  input  logic               mix_done,
  output logic               load_en,
  output logic               sub_en,
  output logic               shift_en,
  output logic               mix_en,
  output logic               ark_en,
  output logic               key_req,
  output logic [ROUND_W-1:0] round_num,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = (MIX_TIMEOUT > 2) ? $clog2(MIX_TIMEOUT) : 1;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);
  localparam logic [CNT_W-1:0]   MIX_LAST   = CNT_W'(MIX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARK, S_SUB, S_SHIFT, S_MIX, S_DONE, S_ERR
  } state_t;

  state_t             state, state_nxt;
  logic [ROUND_W-1:0] round_nxt;
  logic [CNT_W-1:0]   mix_cnt, mix_cnt_nxt;

  // State, round counter and MixColumns wait counter; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      round_num <= '0;
      mix_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      round_num <= round_nxt;
      mix_cnt   <= mix_cnt_nxt;
    end
  end

  // Next-state, counter updates and stage strobes decoded from the current state.
  always_comb begin
    state_nxt   = state;
    round_nxt   = round_num;
    mix_cnt_nxt = mix_cnt;
    load_en     = 1'b0;
    sub_en      = 1'b0;
    shift_en    = 1'b0;
    mix_en      = 1'b0;
    ark_en      = 1'b0;
    key_req     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (state != S_IDLE) && (state != S_ERR);

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_en     = 1'b1;
        round_nxt   = '0;
        mix_cnt_nxt = '0;
        state_nxt   = S_ARK;
      end
      S_ARK: begin
        ark_en = key_valid;
        if (key_valid) begin
          if (round_num == LAST_ROUND) begin
            state_nxt = S_DONE;
          end else begin
            round_nxt = round_num + ROUND_W'(1);
            state_nxt = S_SUB;
          end
        end
      end
      S_SUB: begin
        sub_en    = 1'b1;
        key_req   = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en  = 1'b1;
        state_nxt = (round_num == LAST_ROUND) ? S_ARK : S_MIX;
      end
      S_MIX: begin
        mix_en = 1'b1;
        if (mix_done) begin
          mix_cnt_nxt = '0;
          state_nxt   = S_ARK;
        end else if (mix_cnt == MIX_LAST) begin
          mix_cnt_nxt = '0;
          state_nxt   = S_ERR;
        end else begin
          mix_cnt_nxt = mix_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
